chan_reload_sequencer: RTL and testbench
========================================

Name: chan_reload_sequencer

Overview:
- Stages channelizer coefficient sets and down-select masks written by the register interface, then streams each set as an AXI-Stream packet into the channelizer reload and select ports.
- A single read/stream engine is shared between the two buffers. Round-robin arbitration picks which pending job runs.
- Sits between the register bank and the channelizer core. It replaces toggle-based single-word pushes with atomic, length-checked packet transfers.

Parameters:
- COEFF_DEPTH, 512, coefficient buffer depth in 32-bit words (power of 2)
- MASK_DEPTH, 256, mask buffer depth in 32-bit words (power of 2)
- CA_W, 9, log2(COEFF_DEPTH)
- MA_W, 8, log2(MASK_DEPTH)

Ports:
- clk  in  1  single clock
- resetn  in  1  synchronous active-low reset
- cfg_wr_en  in  1  write strobe into the staging buffer
- cfg_wr_sel  in  1  0 = coefficient buffer, 1 = mask buffer
- cfg_wr_addr  in  CA_W  word address (upper bit ignored for mask)
- cfg_wr_data  in  32  word to store
- cfg_coeff_len  in  CA_W+1  coefficient word count N
- cfg_mask_len  in  MA_W+1  mask word count N
- cfg_coeff_go  in  1  single-cycle pulse: request coefficient transfer
- cfg_mask_go  in  1  single-cycle pulse: request mask transfer
- cfg_err_clr  in  1  pulse: clear err_* flags
- m_reload_tvalid/tdata[31:0]/tlast  out  1/32/1  to channelizer reload port
- m_reload_tready  in  1
- m_select_tvalid/tdata[31:0]/tlast  out  1/32/1  to channelizer select port
- m_select_tready  in  1
- busy  out  1  a job is pending or streaming
- coeff_done, mask_done  out  1 each  single-cycle pulse when the last word handshakes
- err_len, err_overrun, err_wr_busy  out  1 each  sticky error flags

Behaviour:
- Reset (resetn=0 at a rising edge): all tvalid/tlast low, tdata 0, done pulses 0, err_* 0, pending flags cleared, RR pointer = coeff, FSM = IDLE. Buffer contents are not cleared.
- Reset mid-stream: tvalid drops on the following edge and the packet is truncated. The channelizer is re-synced by its own reset.
- Buffers: 1 write port and 1 read port each; 1-cycle registered read latency.
- Go handling:
  - A go pulse with len == 0 or len > DEPTH is dropped and sets err_len.
  - A go pulse while that job is already pending or streaming is dropped and sets err_overrun.
  - Otherwise the pending flag for that job is set. Lengths are latched at go time.
- Arbitration (FSM in IDLE, any pending):
  - If only one job is pending, it is granted.
  - If both are pending, the job pointed to by RR is granted and RR flips to the other.
  - Simultaneous go pulses from IDLE: coefficient wins after reset.
- FSM:
  - IDLE -> FETCH on grant; word index = 0.
  - FETCH: drive read address = index -> LOAD.
  - LOAD: capture read data into the output register; assert tvalid; tlast = (index == N-1) -> SEND.
  - SEND: hold tdata/tlast/tvalid stable until tready.
    - On handshake, if not last: index += 1 -> FETCH.
    - On handshake, if last: tvalid low, clear the job's pending flag, pulse *_done -> IDLE.
- Throughput: at most 1 word per 3 cycles. Latency from go to first tvalid is 3 cycles when idle.
- Only the granted channel's tvalid is ever high. The other channel's outputs stay 0.
- Writes to the buffer of the job currently pending or streaming are dropped and set err_wr_busy. Writes to the other buffer proceed.
- busy = any pending flag | (FSM != IDLE).
- cfg_err_clr clears all err_* flags. If clear and set occur in the same cycle, set wins.
- cfg_coeff_len/cfg_mask_len may change at any time; only the value latched at go is used.

Test Plan:
- Write 4 coefficient words 0x11..0x44, len=4, go, tready=1 -> reload port carries 0x11,0x22,0x33,0x44; tlast only on 0x44; coeff_done pulses once; select tvalid never high.
- Mask len=3 with tready low for 5 cycles mid-packet -> tdata/tlast held stable while stalled; no word lost or duplicated; mask_done after the 3rd handshake.
- Coefficient and mask go pulses in the same cycle after reset -> coefficient packet runs first, then mask; repeat -> RR order holds; busy deasserts only after both done pulses.
- len=0, then len=COEFF_DEPTH+1 -> no output, err_len=1; cfg_err_clr -> err_len=0.
- Second coefficient go during streaming, plus a write to the coefficient buffer -> err_overrun=1, err_wr_busy=1, transferred data unchanged; a write to the mask buffer during the same stream succeeds.
- resetn low during word 2 of 5 -> tvalid=0 next cycle, busy=0, pending cleared; a new go after reset streams from word 0.

Source files
------------

// File: rtl/chan_reload_sequencer_if.sv
// Register-side staging/control bus plus the two AXI-Stream outputs of chan_reload_sequencer.
// master = register bank / stream sink side, slave = the sequencer.
interface chan_reload_sequencer_if #(
    parameter int CA_W = 9,
    parameter int MA_W = 8
);
    logic            cfg_wr_en;
    logic            cfg_wr_sel;
    logic [CA_W-1:0] cfg_wr_addr;
    logic [31:0]     cfg_wr_data;
    logic [CA_W:0]   cfg_coeff_len;
    logic [MA_W:0]   cfg_mask_len;
    logic            cfg_coeff_go;
    logic            cfg_mask_go;
    logic            cfg_err_clr;

    logic            m_reload_tvalid;
    logic [31:0]     m_reload_tdata;
    logic            m_reload_tlast;
    logic            m_reload_tready;
    logic            m_select_tvalid;
    logic [31:0]     m_select_tdata;
    logic            m_select_tlast;
    logic            m_select_tready;

    logic            busy;
    logic            coeff_done;
    logic            mask_done;
    logic            err_len;
    logic            err_overrun;
    logic            err_wr_busy;

    modport master (
        output cfg_wr_en, cfg_wr_sel, cfg_wr_addr, cfg_wr_data,
               cfg_coeff_len, cfg_mask_len, cfg_coeff_go, cfg_mask_go, cfg_err_clr,
               m_reload_tready, m_select_tready,
        input  m_reload_tvalid, m_reload_tdata, m_reload_tlast,
               m_select_tvalid, m_select_tdata, m_select_tlast,
               busy, coeff_done, mask_done, err_len, err_overrun, err_wr_busy
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_sel, cfg_wr_addr, cfg_wr_data,
               cfg_coeff_len, cfg_mask_len, cfg_coeff_go, cfg_mask_go, cfg_err_clr,
               m_reload_tready, m_select_tready,
        output m_reload_tvalid, m_reload_tdata, m_reload_tlast,
               m_select_tvalid, m_select_tdata, m_select_tlast,
               busy, coeff_done, mask_done, err_len, err_overrun, err_wr_busy
    );
endinterface

// File: rtl/chan_reload_sequencer.sv
// Stages coefficient/mask words and streams each staged set as one AXI-Stream packet,
// sharing a single fetch/stream engine between the two buffers under round-robin arbitration.
module crs_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

module chan_reload_sequencer #(
    parameter int COEFF_DEPTH = 512,
    parameter int MASK_DEPTH  = 256,
    parameter int CA_W        = 9,
    parameter int MA_W        = 8
) (
    input logic                    clk,
    input logic                    resetn,
    chan_reload_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        last;
    } axis_t;

    localparam logic [CA_W:0] C_MAX = (CA_W+1)'(COEFF_DEPTH);
    localparam logic [MA_W:0] M_MAX = (MA_W+1)'(MASK_DEPTH);

    // Channel index 0 = coefficient/reload, 1 = mask/select.
    state_t          state;
    logic            cur;
    logic            rr;
    logic [1:0]      pend;
    logic [1:0]      done;
    axis_t [1:0]     out_q;
    logic [CA_W-1:0] idx;
    logic [CA_W-1:0] c_last;
    logic [MA_W-1:0] m_last;

    logic [31:0]     c_rdata, m_rdata, rdata;
    logic [CA_W:0]   c_len_m1;
    logic [MA_W:0]   m_len_m1;
    logic            c_bad, m_bad, c_go_ok, m_go_ok;
    logic            c_we, m_we, is_last, hs;
    logic            len_set, ovr_set, wrb_set;
    logic [1:0]      tready;
    logic            unused_bits;

    assign c_len_m1 = bus.cfg_coeff_len - {{CA_W{1'b0}}, 1'b1};
    assign m_len_m1 = bus.cfg_mask_len  - {{MA_W{1'b0}}, 1'b1};
    assign c_bad    = (bus.cfg_coeff_len == '0) || (bus.cfg_coeff_len > C_MAX);
    assign m_bad    = (bus.cfg_mask_len  == '0) || (bus.cfg_mask_len  > M_MAX);
    assign c_go_ok  = bus.cfg_coeff_go && !c_bad && !pend[0];
    assign m_go_ok  = bus.cfg_mask_go  && !m_bad && !pend[1];

    assign len_set  = (bus.cfg_coeff_go && c_bad) || (bus.cfg_mask_go && m_bad);
    assign ovr_set  = (bus.cfg_coeff_go && !c_bad && pend[0]) ||
                      (bus.cfg_mask_go  && !m_bad && pend[1]);
    // A pending job owns its buffer until its last word has handshaken.
    assign c_we     = bus.cfg_wr_en && !bus.cfg_wr_sel && !pend[0];
    assign m_we     = bus.cfg_wr_en &&  bus.cfg_wr_sel && !pend[1];
    assign wrb_set  = bus.cfg_wr_en && (bus.cfg_wr_sel ? pend[1] : pend[0]);

    assign rdata    = cur ? m_rdata : c_rdata;
    assign is_last  = cur ? (idx[MA_W-1:0] == m_last) : (idx == c_last);
    assign tready   = {bus.m_select_tready, bus.m_reload_tready};
    assign hs       = tready[cur];

    assign unused_bits = ^{bus.cfg_wr_addr, c_len_m1[CA_W], m_len_m1[MA_W]};

    crs_buf #(.DEPTH(COEFF_DEPTH), .AW(CA_W)) u_coeff_buf (
        .clk   (clk),
        .we    (c_we),
        .waddr (bus.cfg_wr_addr),
        .wdata (bus.cfg_wr_data),
        .raddr (idx),
        .rdata (c_rdata)
    );

    crs_buf #(.DEPTH(MASK_DEPTH), .AW(MA_W)) u_mask_buf (
        .clk   (clk),
        .we    (m_we),
        .waddr (bus.cfg_wr_addr[MA_W-1:0]),
        .wdata (bus.cfg_wr_data),
        .raddr (idx[MA_W-1:0]),
        .rdata (m_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cur    <= 1'b0;
            rr     <= 1'b0;
            pend   <= '0;
            done   <= '0;
            out_q  <= '0;
            idx    <= '0;
            c_last <= '0;
            m_last <= '0;
        end else begin
            done <= '0;
            if (c_go_ok) begin
                pend[0] <= 1'b1;
                c_last  <= c_len_m1[CA_W-1:0];
            end
            if (m_go_ok) begin
                pend[1] <= 1'b1;
                m_last  <= m_len_m1[MA_W-1:0];
            end
            case (state)
                IDLE: begin
                    if (pend != 2'b00) begin
                        if (pend == 2'b11) begin
                            cur <= rr;
                            rr  <= ~rr;
                        end else begin
                            cur <= pend[1];
                        end
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    out_q[cur] <= '{valid: 1'b1, data: rdata, last: is_last};
                    state      <= SEND;
                end
                SEND: begin
                    if (hs) begin
                        out_q[cur] <= '0;
                        if (is_last) begin
                            pend[cur] <= 1'b0;
                            done[cur] <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky errors; a set in the same cycle as a clear survives.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.err_len     <= 1'b0;
            bus.err_overrun <= 1'b0;
            bus.err_wr_busy <= 1'b0;
        end else begin
            bus.err_len     <= (bus.err_len     && !bus.cfg_err_clr) || len_set;
            bus.err_overrun <= (bus.err_overrun && !bus.cfg_err_clr) || ovr_set;
            bus.err_wr_busy <= (bus.err_wr_busy && !bus.cfg_err_clr) || wrb_set;
        end
    end

    assign bus.m_reload_tvalid = out_q[0].valid;
    assign bus.m_reload_tdata  = out_q[0].data;
    assign bus.m_reload_tlast  = out_q[0].last;
    assign bus.m_select_tvalid = out_q[1].valid;
    assign bus.m_select_tdata  = out_q[1].data;
    assign bus.m_select_tlast  = out_q[1].last;
    assign bus.coeff_done      = done[0];
    assign bus.mask_done       = done[1];
    assign bus.busy            = (pend != 2'b00) || (state != IDLE);
endmodule

// File: tb/tb_chan_reload_sequencer.sv
// Directed bench for chan_reload_sequencer: packet content/framing, stalls, arbitration,
// length/overrun/write-busy errors and mid-stream reset.
module tb_chan_reload_sequencer;
    localparam int CD   = 512;
    localparam int MD   = 256;
    localparam int CA_W = 9;
    localparam int MA_W = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    chan_reload_sequencer_if #(.CA_W(CA_W), .MA_W(MA_W)) bus ();

    chan_reload_sequencer #(
        .COEFF_DEPTH (CD),
        .MASK_DEPTH  (MD),
        .CA_W        (CA_W),
        .MA_W        (MA_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [32:0] rq[$];
    logic [32:0] sq[$];
    int          chq[$];
    int          cdone, mdone, stalls, stall_bad, both_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input int addr, input logic [31:0] d);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_sel  = sel;
        bus.cfg_wr_addr = addr[CA_W-1:0];
        bus.cfg_wr_data = d;
        tick();
        bus.cfg_wr_en   = 1'b0;
    endtask

    task automatic go(input bit c, input bit m);
        bus.cfg_coeff_go = c;
        bus.cfg_mask_go  = m;
        tick();
        bus.cfg_coeff_go = 1'b0;
        bus.cfg_mask_go  = 1'b0;
    endtask

    task automatic err_clr;
        bus.cfg_err_clr = 1'b1;
        tick();
        bus.cfg_err_clr = 1'b0;
    endtask

    // Runs until busy drops, logging every handshake; stalls stall_n valid cycles after
    // stall_after handshakes and flags any change of the held word during a stall.
    task automatic collect(input int budget, input int stall_after, input int stall_n);
        int          cyc = 0;
        int          hs  = 0;
        bit          holding = 1'b0;
        logic [32:0] held = '0;
        logic [32:0] w;
        rq.delete(); sq.delete(); chq.delete();
        cdone = 0; mdone = 0; stalls = 0; stall_bad = 0; both_hi = 0;
        forever begin
            bus.m_reload_tready = !(hs == stall_after && stalls < stall_n);
            bus.m_select_tready = bus.m_reload_tready;
            @(negedge clk);
            cyc++;
            if (bus.m_reload_tvalid && bus.m_select_tvalid) both_hi++;
            if (bus.coeff_done) cdone++;
            if (bus.mask_done) mdone++;
            if (bus.m_reload_tvalid || bus.m_select_tvalid) begin
                w = bus.m_reload_tvalid ? {bus.m_reload_tlast, bus.m_reload_tdata}
                                        : {bus.m_select_tlast, bus.m_select_tdata};
                if (holding && w !== held) stall_bad++;
                if (bus.m_reload_tready) begin
                    if (bus.m_reload_tvalid) rq.push_back(w);
                    else sq.push_back(w);
                    chq.push_back(bus.m_reload_tvalid ? 0 : 1);
                    hs++;
                    holding = 1'b0;
                end else begin
                    stalls++;
                    holding = 1'b1;
                    held    = w;
                end
            end
            if ((!bus.busy && cyc > 1) || cyc >= budget) break;
            tick();
        end
        bus.m_reload_tready = 1'b1;
        bus.m_select_tready = 1'b1;
        check("budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_wr_en = 1'b0; bus.cfg_wr_sel = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.cfg_coeff_len = '0; bus.cfg_mask_len = '0;
        bus.cfg_coeff_go = 1'b0; bus.cfg_mask_go = 1'b0; bus.cfg_err_clr = 1'b0;
        bus.m_reload_tready = 1'b1; bus.m_select_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_rvalid", 32'(bus.m_reload_tvalid), 32'd0);
        check("rst_svalid", 32'(bus.m_select_tvalid), 32'd0);
        check("rst_rdata",  bus.m_reload_tdata, 32'd0);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_err",    32'({bus.err_len, bus.err_overrun, bus.err_wr_busy}), 32'd0);

        // basic coefficient packet; length changed after go must be ignored
        for (int i = 0; i < 4; i++) wr(1'b0, i, 32'h11 * 32'(i + 1));
        bus.cfg_coeff_len = 10'd4;
        go(1'b1, 1'b0);
        bus.cfg_coeff_len = 10'd7;
        collect(100, -1, 0);
        check("t1_nwords", 32'(rq.size()), 32'd4);
        for (int i = 0; i < rq.size() && i < 4; i++) begin
            check($sformatf("t1_w%0d", i), rq[i][31:0], 32'h11 * 32'(i + 1));
            check($sformatf("t1_last%0d", i), 32'(rq[i][32]), 32'(i == 3));
        end
        check("t1_sel_idle", 32'(sq.size()), 32'd0);
        check("t1_cdone", 32'(cdone), 32'd1);
        check("t1_both", 32'(both_hi), 32'd0);

        // mask packet with a 5-cycle stall on the second word
        for (int i = 0; i < 3; i++) wr(1'b1, i, 32'hA1 + 32'(i));
        bus.cfg_mask_len = 9'd3;
        go(1'b0, 1'b1);
        collect(100, 1, 5);
        check("t2_nwords", 32'(sq.size()), 32'd3);
        for (int i = 0; i < sq.size() && i < 3; i++) begin
            check($sformatf("t2_w%0d", i), sq[i][31:0], 32'hA1 + 32'(i));
            check($sformatf("t2_last%0d", i), 32'(sq[i][32]), 32'(i == 2));
        end
        check("t2_stalls", 32'(stalls), 32'd5);
        check("t2_stable", 32'(stall_bad), 32'd0);
        check("t2_mdone", 32'(mdone), 32'd1);
        check("t2_rel_idle", 32'(rq.size()), 32'd0);

        // simultaneous go after reset: coeff first; contested again: mask first
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.cfg_coeff_len = 10'd4;
        go(1'b1, 1'b1);
        collect(200, -1, 0);
        check("t3a_nwords", 32'(chq.size()), 32'd7);
        if (chq.size() == 7) begin
            check("t3a_first", 32'(chq[0]), 32'd0);
            check("t3a_second", 32'(chq[4]), 32'd1);
        end
        check("t3a_dones", 32'(cdone + mdone), 32'd2);
        check("t3a_both", 32'(both_hi), 32'd0);
        go(1'b1, 1'b1);
        collect(200, -1, 0);
        check("t3b_nwords", 32'(chq.size()), 32'd7);
        if (chq.size() == 7) begin
            check("t3b_first", 32'(chq[0]), 32'd1);
            check("t3b_second", 32'(chq[3]), 32'd0);
        end
        check("t3b_dones", 32'(cdone + mdone), 32'd2);

        // length errors
        bus.cfg_coeff_len = 10'd0;
        go(1'b1, 1'b0);
        collect(20, -1, 0);
        check("t4_len0_out", 32'(rq.size()), 32'd0);
        check("t4_len0_err", 32'(bus.err_len), 32'd1);
        err_clr();
        check("t4_clr", 32'(bus.err_len), 32'd0);
        bus.cfg_coeff_len = 10'(CD + 1);
        go(1'b1, 1'b0);
        collect(20, -1, 0);
        check("t4_big_out", 32'(rq.size()), 32'd0);
        check("t4_big_err", 32'(bus.err_len), 32'd1);
        check("t4_no_ovr", 32'(bus.err_overrun), 32'd0);
        err_clr();
        bus.cfg_mask_len = 9'(MD + 1);
        go(1'b0, 1'b1);
        check("t4_mbig_err", 32'(bus.err_len), 32'd1);
        err_clr();

        // overrun and busy-buffer write during a stalled coefficient stream
        bus.cfg_coeff_len = 10'd4;
        bus.cfg_mask_len  = 9'd1;
        bus.m_reload_tready = 1'b0;
        go(1'b1, 1'b0);
        repeat (5) tick();
        go(1'b1, 1'b0);
        wr(1'b0, 1, 32'hDEAD);
        wr(1'b1, 0, 32'h77);
        check("t5_ovr", 32'(bus.err_overrun), 32'd1);
        check("t5_wrb", 32'(bus.err_wr_busy), 32'd1);
        check("t5_len", 32'(bus.err_len), 32'd0);
        collect(100, -1, 0);
        check("t5_nwords", 32'(rq.size()), 32'd4);
        for (int i = 0; i < rq.size() && i < 4; i++)
            check($sformatf("t5_w%0d", i), rq[i][31:0], 32'h11 * 32'(i + 1));
        go(1'b0, 1'b1);
        collect(50, -1, 0);
        check("t5_mask_n", 32'(sq.size()), 32'd1);
        if (sq.size() == 1) check("t5_mask_w", {sq[0][32], sq[0][31:0]} == {1'b1, 32'h77} ? 32'd1 : 32'd0, 32'd1);
        err_clr();

        // reset while word 2 of 5 is on the port
        for (int i = 0; i < 5; i++) wr(1'b0, i, 32'h100 + 32'(i));
        bus.cfg_coeff_len = 10'd5;
        bus.m_reload_tready = 1'b0;
        go(1'b1, 1'b0);
        repeat (4) tick();
        bus.m_reload_tready = 1'b1;
        tick();
        bus.m_reload_tready = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("t6_mid_valid", 32'(bus.m_reload_tvalid), 32'd1);
        check("t6_mid_data", bus.m_reload_tdata, 32'h101);
        resetn = 1'b0;
        tick();
        check("t6_rst_valid", 32'(bus.m_reload_tvalid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        resetn = 1'b1;
        bus.m_reload_tready = 1'b1;
        go(1'b1, 1'b0);
        collect(100, -1, 0);
        check("t6_nwords", 32'(rq.size()), 32'd5);
        for (int i = 0; i < rq.size() && i < 5; i++)
            check($sformatf("t6_w%0d", i), rq[i][31:0], 32'h100 + 32'(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
